// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline sequencing controller for the 5-stage MIPS32 core.
// Merges ID/EX stall requests, owns the multi-cycle countdown and the flush
// sequencer, and drives the per-stage stall vector plus flush/redirect PC.
// Optional feature: define PIPE_STALL_CTRL_PERF_EN to build the saturating
// stall-cycle performance counter; otherwise perf_stall_cnt_o is tied to 0.
module pipe_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             mc_start_i,
  input  logic [CNT_W-1:0] mc_cycles_i,
  input  logic             flush_req_i,
  input  logic [31:0]      flush_pc_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             busy_o,
  output logic [31:0]      perf_stall_cnt_o
);

  localparam logic [5:0] STALL_ID = 6'b000111;
  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [2:0] FL_LOAD  = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MULTI,
    ST_FLUSH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_mc_cnt;
  logic [CNT_W-1:0]   w_mc_cnt_nxt;
  logic [2:0]         r_fl_cnt;
  logic [2:0]         w_fl_cnt_nxt;
  logic [31:0]        r_new_pc;
  logic [31:0]        w_new_pc_nxt;
  logic               r_busy;
  logic [5:0]         w_stall;

  // State, counters, redirect PC and busy flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= '0;
      r_fl_cnt <= '0;
      r_new_pc <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
      r_fl_cnt <= w_fl_cnt_nxt;
      r_new_pc <= w_new_pc_nxt;
      r_busy   <= (w_state_nxt != ST_RUN);
    end
  end

  // Next-state, counter updates and combinational stall vector by priority
  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    w_fl_cnt_nxt = r_fl_cnt;
    w_new_pc_nxt = r_new_pc;
    w_stall      = '0;
    unique case (r_state)
      ST_RUN: begin
        if (flush_req_i) begin
          w_state_nxt  = ST_FLUSH;
          w_fl_cnt_nxt = FL_LOAD;
          w_new_pc_nxt = flush_pc_i;
        end else if (mc_start_i && (mc_cycles_i != '0)) begin
          w_stall = STALL_EX;
          // The start cycle is itself the first stall cycle, so only N-1
          // further cycles are spent in MULTI.
          if (mc_cycles_i != CNT_W'(1)) begin
            w_mc_cnt_nxt = mc_cycles_i - CNT_W'(1);
            w_state_nxt  = ST_MULTI;
          end
        end else if (stallreq_ex_i) begin
          w_stall = STALL_EX;
        end else if (stallreq_id_i) begin
          w_stall = STALL_ID;
        end
      end
      ST_MULTI: begin
        w_stall = STALL_EX;
        if (flush_req_i) begin
          w_state_nxt  = ST_FLUSH;
          w_mc_cnt_nxt = '0;
          w_fl_cnt_nxt = FL_LOAD;
          w_new_pc_nxt = flush_pc_i;
        end else if (r_mc_cnt <= CNT_W'(1)) begin
          w_state_nxt  = ST_RUN;
          w_mc_cnt_nxt = '0;
        end else begin
          w_mc_cnt_nxt = r_mc_cnt - CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (flush_req_i) begin
          w_fl_cnt_nxt = FL_LOAD;
          w_new_pc_nxt = flush_pc_i;
        end else if (r_fl_cnt <= 3'd1) begin
          w_state_nxt  = ST_RUN;
          w_fl_cnt_nxt = '0;
        end else begin
          w_fl_cnt_nxt = r_fl_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign stall_o  = w_stall;
  assign flush_o  = (r_state == ST_FLUSH);
  assign new_pc_o = r_new_pc;
  assign busy_o   = r_busy;

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] r_perf_cnt;

  // Saturating count of cycles with any stage stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cnt <= '0;
    end else if ((w_stall != '0) && (r_perf_cnt != '1)) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = r_perf_cnt;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule
